// File: rtl/seq_pattern_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
// The package holds:
//   - state_t      detector state: FILL (collecting history) or ARMED (testing every bit)
//   - fill_cnt_w() width of the fill counter for a given pattern length
//   - masked_eq()  compare with don't-care bits; an all-ones mask gives an exact compare
package seq_pattern_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // Widest pattern supported. The compare helper works at this width, and
    // narrower operands are zero-extended by the caller.
    localparam int PAT_W_MAX = 32;

    // The fill counter has to hold the values 0..PAT_W.
    function automatic int fill_cnt_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    function automatic logic masked_eq(input logic [PAT_W_MAX-1:0] sr,
                                       input logic [PAT_W_MAX-1:0] pat,
                                       input logic [PAT_W_MAX-1:0] mask);
        return ((sr ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_pattern_det_if.sv
// Bus interface for seq_pattern_det.
// The master side drives the serial stream and the controls:
//   - in_valid, in  : qualified serial input bit
//   - pat_load      : one-cycle strobe that loads pat_in
//   - pat_in        : new pattern, MSB is the first bit received
//   - cnt_clr       : clears the match counter
// The slave side returns:
//   - match         : one-cycle pulse per detection
//   - armed         : PAT_W bits have been accepted since the last restart
//   - match_cnt     : saturating match count
// When SEQ_PATTERN_DET_MASK_EN is defined, the interface also carries
// pat_mask_in, which pat_load loads together with pat_in.
interface seq_pattern_det_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
`ifdef SEQ_PATTERN_DET_MASK_EN
    logic [PAT_W-1:0] pat_mask_in;
`endif
    logic             cnt_clr;
    logic             match;
    logic             armed;
    logic [CNT_W-1:0] match_cnt;

`ifdef SEQ_PATTERN_DET_MASK_EN
    modport master (output in_valid, in, pat_load, pat_in, pat_mask_in, cnt_clr,
                    input  match, armed, match_cnt);
    modport slave  (input  in_valid, in, pat_load, pat_in, pat_mask_in, cnt_clr,
                    output match, armed, match_cnt);
`else
    modport master (output in_valid, in, pat_load, pat_in, cnt_clr,
                    input  match, armed, match_cnt);
    modport slave  (input  in_valid, in, pat_load, pat_in, cnt_clr,
                    output match, armed, match_cnt);
`endif
endinterface

// File: rtl/seq_pattern_det_sat_counter.sv
// Saturating up-counter with a clear input. It is also reused for the
// room-occupancy counters.
// Ports:
//   - clk, rst : clock and synchronous active-high reset
//   - inc      : count one event
//   - clr      : clear the count
//   - count    : current value; holds at 2^WIDTH-1 and never wraps
// When clr and inc are both high on the same edge, the count becomes 1, so
// the coincident event is not lost.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && count != MAX) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_det.sv
// Serial pattern detector for the Smart Room sound/event front end.
// It compares a qualified 1-bit stream against a PAT_W-bit pattern that can be
// loaded at runtime. Detection can be overlapping or non-overlapping
// (OVERLAP), and a saturating counter tracks the number of matches.
// Ports:
//   - clk, rst : clock and synchronous active-high reset
//   - bus      : seq_pattern_det_if.slave
//                (in_valid/in stream, pat_load/pat_in, cnt_clr,
//                 match/armed/match_cnt outputs)
// Optional feature: define SEQ_PATTERN_DET_MASK_EN to add a per-bit
// don't-care mask. The mask is loaded from bus.pat_mask_in and resets to all
// ones.
module seq_pattern_det
    import seq_pattern_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter int               CNT_W   = 8,
    parameter int               OVERLAP = 1,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(3'b101)
) (
    input  logic              clk,
    input  logic              rst,
    seq_pattern_det_if.slave  bus
);

    localparam int FILL_W = fill_cnt_w(PAT_W);

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  sr_q;
    logic [PAT_W-1:0]  sr_next;
    logic [FILL_W-1:0] fill_q;
    state_t            state_q;
    logic              match_q;
    logic              armed_q;
    logic              accept;
    logic              complete;
    logic              hit;
`ifdef SEQ_PATTERN_DET_MASK_EN
    logic [PAT_W-1:0]  mask_q;
`endif

    // The oldest bit leaves at the MSB. The cast drops it instead of slicing,
    // so the whole register stays in use.
    assign sr_next = PAT_W'({sr_q, bus.in});

    always_comb begin
        accept   = bus.in_valid && !bus.pat_load;
        // This accept either completes the first PAT_W bits or is made while already armed.
        complete = (state_q == ARMED) || (fill_q == FILL_W'(PAT_W - 1));
`ifdef SEQ_PATTERN_DET_MASK_EN
        hit = accept && complete &&
              masked_eq(PAT_W_MAX'(sr_next), PAT_W_MAX'(pat_q), PAT_W_MAX'(mask_q));
`else
        hit = accept && complete &&
              masked_eq(PAT_W_MAX'(sr_next), PAT_W_MAX'(pat_q), '1);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= RST_PAT;
            sr_q    <= '0;
            fill_q  <= '0;
            state_q <= FILL;
            match_q <= 1'b0;
            armed_q <= 1'b0;
`ifdef SEQ_PATTERN_DET_MASK_EN
            mask_q  <= '1;
`endif
        end else if (bus.pat_load) begin
            // A new pattern restarts detection. Any bit arriving in the same cycle is dropped.
            pat_q   <= bus.pat_in;
            sr_q    <= '0;
            fill_q  <= '0;
            state_q <= FILL;
            match_q <= 1'b0;
            armed_q <= 1'b0;
`ifdef SEQ_PATTERN_DET_MASK_EN
            mask_q  <= bus.pat_mask_in;
`endif
        end else if (bus.in_valid) begin
            sr_q    <= sr_next;
            match_q <= hit;
            if (hit && OVERLAP == 0) begin
                // Non-overlapping: the next match needs PAT_W fresh bits.
                fill_q  <= '0;
                state_q <= FILL;
                armed_q <= 1'b0;
            end else if (complete) begin
                fill_q  <= FILL_W'(PAT_W);
                state_q <= ARMED;
                armed_q <= 1'b1;
            end else begin
                fill_q  <= fill_q + FILL_W'(1);
            end
        end else begin
            match_q <= 1'b0;
        end
    end

    assign bus.match = match_q;
    assign bus.armed = armed_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit),
        .clr   (bus.cnt_clr),
        .count (bus.match_cnt)
    );

endmodule

// File: tb/tb_seq_pattern_det.sv
// Self-checking bench for seq_pattern_det.
// It drives three instances:
//   - dut_a : PAT_W=3, CNT_W=8, overlapping detection
//   - dut_b : PAT_W=3, CNT_W=8, non-overlapping detection
//   - dut_c : PAT_W=3, CNT_W=2, overlapping detection (counter saturation)
// Each step drives one instance for one clock and pushes the expected
// {match, armed, match_cnt} onto a scoreboard queue. The entry is popped and
// compared #1 after the edge.
// The mask section runs only when SEQ_PATTERN_DET_MASK_EN is defined.
module tb_seq_pattern_det;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_pattern_det_if #(.PAT_W(3), .CNT_W(8)) ifa ();
    seq_pattern_det_if #(.PAT_W(3), .CNT_W(8)) ifb ();
    seq_pattern_det_if #(.PAT_W(3), .CNT_W(2)) ifc ();

    seq_pattern_det #(.PAT_W(3), .CNT_W(8), .OVERLAP(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_pattern_det #(.PAT_W(3), .CNT_W(8), .OVERLAP(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_pattern_det #(.PAT_W(3), .CNT_W(2), .OVERLAP(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    typedef struct {
        int         sel;
        logic       m;
        logic       a;
        logic [7:0] c;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic idle_all();
        ifa.in_valid = 0; ifa.in = 0; ifa.pat_load = 0; ifa.pat_in = '0; ifa.cnt_clr = 0;
        ifb.in_valid = 0; ifb.in = 0; ifb.pat_load = 0; ifb.pat_in = '0; ifb.cnt_clr = 0;
        ifc.in_valid = 0; ifc.in = 0; ifc.pat_load = 0; ifc.pat_in = '0; ifc.cnt_clr = 0;
`ifdef SEQ_PATTERN_DET_MASK_EN
        ifa.pat_mask_in = '1; ifb.pat_mask_in = '1; ifc.pat_mask_in = '1;
`endif
    endtask

    // Reads one instance's outputs and compares them with the oldest expectation.
    task automatic check_out();
        exp_t       e;
        logic       am;
        logic       aa;
        logic [7:0] ac;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
            return;
        end
        e = exp_q.pop_front();
        case (e.sel)
            0:       begin am = ifa.match; aa = ifa.armed; ac = ifa.match_cnt; end
            1:       begin am = ifb.match; aa = ifb.armed; ac = ifb.match_cnt; end
            default: begin am = ifc.match; aa = ifc.armed; ac = 8'(ifc.match_cnt); end
        endcase
        chk({e.tag, ".match"}, 8'(am), 8'(e.m));
        chk({e.tag, ".armed"}, 8'(aa), 8'(e.a));
        chk({e.tag, ".cnt"},   ac,     e.c);
    endtask

    // Drives one cycle on the selected instance and queues that instance's expected outputs.
    task automatic step(input string tag, input int sel, input logic v, input logic b,
                        input logic ld, input logic [2:0] p, input logic [2:0] pm,
                        input logic clr, input logic em, input logic ea, input logic [7:0] ec);
        exp_t e;
        idle_all();
        case (sel)
            0: begin
                ifa.in_valid = v; ifa.in = b; ifa.pat_load = ld; ifa.pat_in = p; ifa.cnt_clr = clr;
`ifdef SEQ_PATTERN_DET_MASK_EN
                ifa.pat_mask_in = pm;
`endif
            end
            1: begin
                ifb.in_valid = v; ifb.in = b; ifb.pat_load = ld; ifb.pat_in = p; ifb.cnt_clr = clr;
`ifdef SEQ_PATTERN_DET_MASK_EN
                ifb.pat_mask_in = pm;
`endif
            end
            default: begin
                ifc.in_valid = v; ifc.in = b; ifc.pat_load = ld; ifc.pat_in = p; ifc.cnt_clr = clr;
`ifdef SEQ_PATTERN_DET_MASK_EN
                ifc.pat_mask_in = pm;
`endif
            end
        endcase
`ifndef SEQ_PATTERN_DET_MASK_EN
        if (pm != 3'b111) $display("note: mask argument ignored in this build");
`endif
        e.sel = sel; e.m = em; e.a = ea; e.c = ec; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        idle_all();
        check_out();
    endtask

    task automatic do_reset(input string tag);
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk({tag, ".a.match"}, 8'(ifa.match), 8'd0);
        chk({tag, ".a.armed"}, 8'(ifa.armed), 8'd0);
        chk({tag, ".a.cnt"},   ifa.match_cnt, 8'd0);
        chk({tag, ".b.match"}, 8'(ifb.match), 8'd0);
        chk({tag, ".b.cnt"},   ifb.match_cnt, 8'd0);
        chk({tag, ".c.match"}, 8'(ifc.match), 8'd0);
        chk({tag, ".c.cnt"},   8'(ifc.match_cnt), 8'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        do_reset("reset");

        // A: reset pattern 101, stream 1,0,1,0,1 with overlap -> two matches
        step("a_b1", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd0);
        step("a_b2", 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 0, 8'd0);
        step("a_b3", 0, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd1);
        step("a_b4", 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 1, 8'd1);
        step("a_b5", 0, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd2);
        step("a_idle", 0, 0, 0, 0, 3'b000, 3'b111, 0, 0, 1, 8'd2);

        // A: reload 101 with a discarded bit, then 1,0,1 separated by 5-cycle gaps
        step("a_ld101", 0, 1, 1, 1, 3'b101, 3'b111, 0, 0, 0, 8'd2);
        step("a_g1", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd2);
        for (int i = 0; i < 5; i++) step("a_gap1", 0, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd2);
        step("a_g2", 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 0, 8'd2);
        for (int i = 0; i < 5; i++) step("a_gap2", 0, 0, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd2);
        step("a_g3", 0, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd3);
        step("a_g_after", 0, 0, 0, 0, 3'b000, 3'b111, 0, 0, 1, 8'd3);

        // A: load 110 with a coincident valid bit that must be ignored
        step("a_ld110", 0, 1, 1, 1, 3'b110, 3'b111, 0, 0, 0, 8'd3);
        step("a_p1", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd3);
        step("a_p2", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd3);
        step("a_p3", 0, 1, 0, 0, 3'b000, 3'b111, 0, 1, 1, 8'd4);

        // A: cnt_clr alone, then cnt_clr coincident with a detection
        step("a_clr", 0, 0, 0, 0, 3'b000, 3'b111, 1, 0, 1, 8'd0);
        step("a_q1", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 1, 8'd0);
        step("a_q2", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 1, 8'd0);
        step("a_q3clr", 0, 1, 0, 0, 3'b000, 3'b111, 1, 1, 1, 8'd1);

        // B: non-overlapping, stream 1,0,1,0,1 -> one match; two more bits complete a fresh window
        step("b_b1", 1, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd0);
        step("b_b2", 1, 1, 0, 0, 3'b000, 3'b111, 0, 0, 0, 8'd0);
        step("b_b3", 1, 1, 1, 0, 3'b000, 3'b111, 0, 1, 0, 8'd1);
        step("b_b4", 1, 1, 0, 0, 3'b000, 3'b111, 0, 0, 0, 8'd1);
        step("b_b5", 1, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd1);
        step("b_b6", 1, 1, 0, 0, 3'b000, 3'b111, 0, 0, 1, 8'd1);
        step("b_b7", 1, 1, 1, 0, 3'b000, 3'b111, 0, 1, 0, 8'd2);

        // C: pattern 111 and a run of ones -> back-to-back matches, count saturates at 3
        step("c_ld111", 2, 0, 0, 1, 3'b111, 3'b111, 0, 0, 0, 8'd0);
        step("c_1", 2, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd0);
        step("c_2", 2, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd0);
        step("c_m1", 2, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd1);
        step("c_m2", 2, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd2);
        step("c_m3", 2, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd3);
        step("c_m4", 2, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd3);
        step("c_m5", 2, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd3);
        step("c_m6", 2, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd3);
        step("c_clrhit", 2, 1, 1, 0, 3'b000, 3'b111, 1, 1, 1, 8'd1);
        step("c_clr", 2, 0, 0, 0, 3'b000, 3'b111, 1, 0, 1, 8'd0);
        step("c_miss", 2, 1, 0, 0, 3'b000, 3'b111, 0, 0, 1, 8'd0);

        // A: reset in the middle of a stream loses the history and restores pattern 101
        step("a_r1", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 1, 8'd1);
        do_reset("midreset");
        step("a_r2", 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 0, 8'd0);
        step("a_r3", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd0);
        step("a_r4", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 1, 8'd0);
        step("a_r5", 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 1, 8'd0);
        step("a_r6", 0, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd1);

`ifdef SEQ_PATTERN_DET_MASK_EN
        // A: pattern 101 mask 101 -> 1,1,1 and 1,0,1 both match; mask 111 rejects 1,1,1
        step("m_ld", 0, 0, 0, 1, 3'b101, 3'b101, 0, 0, 0, 8'd1);
        step("m_a1", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd1);
        step("m_a2", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd1);
        step("m_a3", 0, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd2);
        step("m_ld2", 0, 0, 0, 1, 3'b101, 3'b101, 0, 0, 0, 8'd2);
        step("m_b1", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd2);
        step("m_b2", 0, 1, 0, 0, 3'b000, 3'b111, 0, 0, 0, 8'd2);
        step("m_b3", 0, 1, 1, 0, 3'b000, 3'b111, 0, 1, 1, 8'd3);
        step("m_ld3", 0, 0, 0, 1, 3'b101, 3'b111, 0, 0, 0, 8'd3);
        step("m_c1", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd3);
        step("m_c2", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 0, 8'd3);
        step("m_c3", 0, 1, 1, 0, 3'b000, 3'b111, 0, 0, 1, 8'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_det.md
Name: seq_pattern_det

Overview:
- Parametrised serial pattern detector for the Smart Room sound/event front end.
- Compares a 1-bit serial input stream against a runtime-loadable PAT_W-bit pattern.
- Supports overlapping or non-overlapping detection and a saturating match counter for the room controller.
- Generalises the fixed 3-symbol detectors with programmable width, pattern, input qualifier and mode.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of the match counter.
- OVERLAP, 1, 1 = overlapping detection, 0 = non-overlapping (history discarded after each match).
- RST_PAT, 3'b101 zero-extended to PAT_W, pattern register value after reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies `in`; a bit is accepted only when high.
- in  in  1  serial data bit.
- pat_load  in  1  one-cycle strobe; loads pat_in into the pattern register.
- pat_in  in  PAT_W  new pattern; MSB is the first bit received.
- cnt_clr  in  1  clears match_cnt.
- match  out  1  one-cycle pulse per detected pattern.
- armed  out  1  high once PAT_W bits have been accepted since the last restart.
- match_cnt  out  CNT_W  saturating count of matches.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Pattern register = RST_PAT; shift register = 0; fill counter = 0; state = FILL.
  - match = 0, armed = 0, match_cnt = 0.
- Shifting: each accepted bit (in_valid = 1) shifts in LSB-side: sr_next = {sr[PAT_W-2:0], in}. Oldest bit sits at the MSB.
- State machine (states FILL, ARMED):
  - FILL: fill counter increments per accepted bit. The accept that brings the count to PAT_W moves to ARMED, and the match test applies on that same accept.
  - ARMED: every accepted bit is tested.
  - OVERLAP = 0: a match clears the fill counter and the state returns to FILL; the next match needs PAT_W fresh bits.
  - OVERLAP = 1: a match leaves the state in ARMED.
- Match test: sr_next == pattern register.
  - match is registered: high exactly the cycle after the edge that accepted the completing bit, low otherwise.
  - Back-to-back matches (OVERLAP = 1, pattern 11, stream 111) give consecutive high cycles.
- armed: registered; equals (state == ARMED).
- in_valid = 0: no shift, no count change, no test; match drops to 0 that cycle.
- pat_load = 1:
  - Pattern register <= pat_in; shift register and fill counter cleared; state <= FILL; match <= 0.
  - Any in_valid bit in the same cycle is discarded.
  - match_cnt is unaffected.
- match_cnt: increments on the same edge that sets match; saturates at 2^CNT_W - 1 with no wrap.
  - cnt_clr alone: count <= 0.
  - cnt_clr and a detection on the same edge: count <= 1.
- Priority: rst > pat_load > in_valid; cnt_clr is independent of the other controls.
- Reset mid-stream: all partial history is lost; no match in the cycle after reset.

Optional Feature:
- Macro: SEQ_PATTERN_DET_MASK_EN.
- Defined:
  - Adds port pat_mask_in (in, PAT_W), loaded by pat_load alongside pat_in into a mask register; reset value all ones.
  - Match test becomes ((sr_next ^ pattern) & mask) == 0; bits with mask 0 are don't-care.
  - Fill/arming rules are unchanged, so a full PAT_W bits is still required.
- Undefined: no port, no mask register; exact compare only.

Decomposition:
- Package seq_pattern_det_pkg:
  - State enum typedef (FILL, ARMED).
  - Localparam for the fill-counter width: $clog2(PAT_W+1).
  - Function for the masked compare.
- One natural sub-module: sat_counter (parameter WIDTH; inputs inc, clr; output count), using the clr-plus-inc = 1 rule above.
- It is reusable for the room-occupancy counters.

Test Plan:
- Reset, PAT_W = 3, pattern 101, stream 1,0,1 on consecutive valid cycles -> match high only in the cycle after the third bit; match_cnt = 1; armed high from the cycle after the third bit.
- OVERLAP = 1, stream 1,0,1,0,1 -> two match pulses, two valid-bit-cycles apart; match_cnt = 2. With OVERLAP = 0, same stream -> one pulse; match_cnt = 1.
- Stream 1,0,1 with in_valid low for 5 cycles between each bit -> exactly one match pulse after the final accepted bit; no pulses during gaps.
- pat_load pattern 110 in the same cycle as a valid bit, then stream 1,1,0 -> bit ignored, one match; armed low for the cycle after the load.
- CNT_W = 2, six overlapping matches -> match_cnt stays at 3; then cnt_clr coincident with a detection -> match_cnt = 1.
- With SEQ_PATTERN_DET_MASK_EN, pattern 101, mask 101, streams 1,1,1 and 1,0,1 -> both match; mask 111 with 1,1,1 -> no match.
